ext_bus_arbiter: RTL and testbench
==================================

EXT_BUS_ARBITER -- requirements
Module: ext_bus_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255: the number of cycles to wait for a response header before failing.
REQ-002 The block SHALL have these ports:
- ext_clk  in  1  sole clock; all state on rising edge.
- ext_rst_n  in  1  reset, asynchronous and active-low.
- rqN_valid  in  1  (N=0,1) requester N has a frame pending.
- rqN_len  in  3  (N=0,1) payload bytes minus 1 (1..8 bytes).
- rqN_data  in  8  (N=0,1) current payload byte.
- rqN_ready  out  1  (N=0,1) payload byte taken this cycle.
- ob_data  out  8  outbound bus byte.
- ob_pty  out  1  outbound odd parity.
- ib_data  in  8  inbound bus byte.
- ib_pty  in  1  inbound odd parity.
- rsp_valid  out  1  response byte valid.
- rsp_id  out  1  requester owning the response.
- rsp_data  out  8  response byte.
- rsp_last  out  1  final response byte.
- rsp_err  out  1  parity, ID or timeout error on this byte.
- busy  out  1  state not IDLE.

Function
REQ-003 The block SHALL implement states IDLE, DATA, WAIT_RSP and RSP, with one outstanding transaction at a time.
REQ-004 Outbound parity SHALL be ob_pty = ~^ob_data, so the count of ones over the 9 bits is odd. The idle outbound value SHALL be ob_data=0x00, ob_pty=1.
REQ-005 In IDLE with any rqN_valid=1, the block SHALL grant by round-robin:
- on a single request, that requester wins;
- on two requests, the requester not granted last time wins;
- after reset, rq0 wins a tie.
REQ-006 On the grant edge the block SHALL register a header and enter DATA.
- Header on ob_data: {1'b1, id, 3'b000, len}.
- The header SHALL appear on ob_data exactly 1 cycle after the cycle in which rqN_valid was sampled.
- len SHALL be latched at grant; later changes to rqN_len are ignored.
REQ-007 In DATA the granted rqN_ready SHALL be 1 for exactly len+1 consecutive cycles and the other requester's ready SHALL be 0.
- On each of those edges, ob_data is loaded from rqN_data.
- rqN_valid is not rechecked mid-frame.
REQ-008 On the edge that takes the last payload byte, the block SHALL enter WAIT_RSP. On the following edge, ob_data SHALL return to idle (0x00, pty 1).
REQ-009 In WAIT_RSP the block SHALL count cycles. A response header is an ib_data byte with bit7=1, sampled on an edge.
- If the header's bit6 equals the granted id and its parity is good, latch the header's [2:0] as response length and enter RSP. No rsp output is produced for the header.
- If bit6 mismatches or the parity is bad, emit one error byte (rsp_valid=1, rsp_err=1, rsp_last=1, rsp_data=ib_data) and go to IDLE.
REQ-010 If TIMEOUT cycles elapse in WAIT_RSP with no header, the block SHALL emit rsp_valid=1, rsp_err=1, rsp_last=1, rsp_data=0x00 and go to IDLE.
REQ-011 In RSP the block SHALL forward each ib_data byte, one per cycle, for length+1 bytes.
- Outputs are registered: rsp_* is valid the cycle after the byte is on ib_data.
- rsp_err=1 on any byte whose parity is even.
- rsp_last=1 on the final byte, after which the block goes to IDLE.
- A bad-parity byte SHALL NOT abort the response.
REQ-012 rsp_id SHALL equal the granted id whenever rsp_valid=1. rsp_valid SHALL be a 1-cycle pulse per byte, with no backpressure.
REQ-013 A new grant SHALL NOT occur before the edge following the rsp_last byte. IDLE is entered on that edge, and a pending request is granted on the next edge.
REQ-014 Inbound bytes seen in IDLE or DATA SHALL be ignored.
REQ-015 The timeout counter SHALL be wide enough to count TIMEOUT and SHALL clear on every entry to WAIT_RSP.

Reset
REQ-016 While ext_rst_n=0, the block SHALL asynchronously force:
- state IDLE;
- ob_data=0x00, ob_pty=1;
- rq0_ready=0, rq1_ready=0;
- rsp_valid=0, rsp_err=0, rsp_last=0, rsp_data=0x00, rsp_id=0;
- busy=0;
- round-robin pointer to "last granted rq1" (so rq0 wins the first tie);
- timeout counter 0.
REQ-017 Reset asserted mid-transaction SHALL discard the transaction with no rsp pulse. After release, the block SHALL behave exactly as after power-on.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Single frame: rq0 len=2, bytes A1,B2,C3 -> ob_data 0x82, A1, B2, C3 on consecutive cycles, then 0x00. ob_pty matches each byte. rq0_ready high exactly 3 cycles.
- Response: after the frame, ib_data 0x81 (good pty), then 11, 22 -> two rsp_valid pulses, data 11 then 22, rsp_id=0, rsp_last on 22, rsp_err=0.
- Simultaneous: rq0 and rq1 valid from reset -> rq0 granted first, rq1 granted next; with both held, grants alternate 0,1,0,1.
- Errors: response byte with flipped ib_pty -> rsp_err=1 on that byte only, remaining bytes delivered. Header 0xC0 while id=0 -> single error byte, block returns to IDLE.
- Timeout: TIMEOUT=16, no inbound header -> exactly 16 cycles after WAIT_RSP entry, one pulse with rsp_err=1, rsp_last=1, data 0x00; busy drops the next cycle.
- Reset mid-DATA: ext_rst_n low during byte 2 of 8 -> ob_data 0x00/pty 1 immediately, ready 0, no rsp pulse; next frame after release granted to rq0 on a tie.

Source files
------------

// File: rtl/ext_bus_arbiter.sv
// Two-requester external bus arbiter: round-robin grant, framed outbound transfer with
// odd parity, then a single inbound response (or error/timeout byte) routed to the owner.
module ext_bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic       ext_clk,
    input  logic       ext_rst_n,
    input  logic       rq0_valid,
    input  logic [2:0] rq0_len,
    input  logic [7:0] rq0_data,
    output logic       rq0_ready,
    input  logic       rq1_valid,
    input  logic [2:0] rq1_len,
    input  logic [7:0] rq1_data,
    output logic       rq1_ready,
    output logic [7:0] ob_data,
    output logic       ob_pty,
    input  logic [7:0] ib_data,
    input  logic       ib_pty,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [7:0] rsp_data,
    output logic       rsp_last,
    output logic       rsp_err,
    output logic       busy
);

    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, WAIT_RSP, RSP} state_t;

    state_t        state;
    logic          gnt_id;
    logic          last_id;
    logic          fin;
    logic [2:0]    len_q;
    logic [2:0]    cnt;
    logic [TW-1:0] tcnt;
    logic          grant_id;
    logic          ib_good;
    logic          hdr_ok;

    always_comb begin
        grant_id = (rq0_valid && rq1_valid) ? ~last_id : rq1_valid;
        ib_good  = ^{ib_pty, ib_data};
        hdr_ok   = (ib_data[6] == gnt_id) && ib_good;
    end

    assign ob_pty = ~^ob_data;
    assign busy   = (state != IDLE);

    // fin marks the cycle a final rsp byte is on the outputs; IDLE is entered one edge later
    always_ff @(posedge ext_clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            state     <= IDLE;
            gnt_id    <= 1'b0;
            last_id   <= 1'b1;
            fin       <= 1'b0;
            len_q     <= 3'd0;
            cnt       <= 3'd0;
            tcnt      <= '0;
            ob_data   <= 8'h00;
            rq0_ready <= 1'b0;
            rq1_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= 8'h00;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_last  <= 1'b0;
            case (state)
                IDLE: begin
                    if (rq0_valid || rq1_valid) begin
                        gnt_id    <= grant_id;
                        last_id   <= grant_id;
                        len_q     <= grant_id ? rq1_len : rq0_len;
                        ob_data   <= {1'b1, grant_id, 3'b000, (grant_id ? rq1_len : rq0_len)};
                        rq0_ready <= ~grant_id;
                        rq1_ready <= grant_id;
                        cnt       <= 3'd0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    ob_data <= gnt_id ? rq1_data : rq0_data;
                    if (cnt == len_q) begin
                        rq0_ready <= 1'b0;
                        rq1_ready <= 1'b0;
                        tcnt      <= '0;
                        fin       <= 1'b0;
                        state     <= WAIT_RSP;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                WAIT_RSP: begin
                    ob_data <= 8'h00;
                    if (fin) begin
                        fin   <= 1'b0;
                        state <= IDLE;
                    end else if (ib_data[7]) begin
                        if (hdr_ok) begin
                            len_q <= ib_data[2:0];
                            cnt   <= 3'd0;
                            state <= RSP;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_last  <= 1'b1;
                            rsp_data  <= ib_data;
                            rsp_id    <= gnt_id;
                            fin       <= 1'b1;
                        end
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_last  <= 1'b1;
                        rsp_data  <= 8'h00;
                        rsp_id    <= gnt_id;
                        fin       <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                RSP: begin
                    if (fin) begin
                        fin   <= 1'b0;
                        state <= IDLE;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= ~ib_good;
                        rsp_last  <= (cnt == len_q);
                        rsp_data  <= ib_data;
                        rsp_id    <= gnt_id;
                        if (cnt == len_q) begin
                            fin <= 1'b1;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Randomized scoreboard bench for ext_bus_arbiter: the driver pushes expected outbound and
// response bytes from a transaction-level model; negedge monitors pop and compare.
module tb_ext_bus_arbiter;

    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic       id;
        logic [7:0] data;
    } ob_t;

    typedef struct packed {
        logic       id;
        logic [7:0] data;
        logic       last;
        logic       err;
    } rsp_t;

    logic       ext_clk = 1'b0;
    logic       ext_rst_n = 1'b1;
    logic       rq0_valid = 1'b0, rq1_valid = 1'b0;
    logic [2:0] rq0_len = 3'd0, rq1_len = 3'd0;
    logic [7:0] rq0_data = 8'h00, rq1_data = 8'h00;
    logic       rq0_ready, rq1_ready;
    logic [7:0] ob_data;
    logic       ob_pty;
    logic [7:0] ib_data = 8'h00;
    logic       ib_pty = 1'b1;
    logic       rsp_valid, rsp_id, rsp_last, rsp_err, busy;
    logic [7:0] rsp_data;

    ob_t  ob_q[$];
    rsp_t rsp_q[$];
    int   compared = 0;
    int   mismatched = 0;
    int   model_last = 1;

    ext_bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .ext_clk(ext_clk), .ext_rst_n(ext_rst_n),
        .rq0_valid(rq0_valid), .rq0_len(rq0_len), .rq0_data(rq0_data), .rq0_ready(rq0_ready),
        .rq1_valid(rq1_valid), .rq1_len(rq1_len), .rq1_data(rq1_data), .rq1_ready(rq1_ready),
        .ob_data(ob_data), .ob_pty(ob_pty), .ib_data(ib_data), .ib_pty(ib_pty),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 ext_clk = ~ext_clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge ext_clk);
        #1;
    endtask

    // Outbound frame is visible while ready is high plus the two cycles after it drops
    logic mon_p1 = 1'b0, mon_p2 = 1'b0, mon_rdy;
    ob_t  mon_ob;
    rsp_t mon_rsp;
    always @(negedge ext_clk) begin
        if (!ext_rst_n) begin
            mon_p1 = 1'b0;
            mon_p2 = 1'b0;
        end else begin
            mon_rdy = rq0_ready | rq1_ready;
            if (mon_rdy || mon_p1 || mon_p2) begin
                if (ob_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL obUnexpected: got ob_data 0x%0h, expected no frame byte", ob_data);
                end else begin
                    mon_ob = ob_q.pop_front();
                    check_output("obData", {24'b0, ob_data}, {24'b0, mon_ob.data});
                    check_output("obPty", {31'b0, ob_pty}, {31'b0, ~^mon_ob.data});
                    if (mon_rdy)
                        check_output("readyOneHot", {30'b0, rq1_ready, rq0_ready},
                                     mon_ob.id ? 32'd2 : 32'd1);
                end
            end
            mon_p2 = mon_p1;
            mon_p1 = mon_rdy;
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL rspUnexpected: got rsp_data 0x%0h, expected no pulse", rsp_data);
                end else begin
                    mon_rsp = rsp_q.pop_front();
                    check_output("rspData", {24'b0, rsp_data}, {24'b0, mon_rsp.data});
                    check_output("rspId", {31'b0, rsp_id}, {31'b0, mon_rsp.id});
                    check_output("rspLast", {31'b0, rsp_last}, {31'b0, mon_rsp.last});
                    check_output("rspErr", {31'b0, rsp_err}, {31'b0, mon_rsp.err});
                end
            end
        end
    end

    // kind: 0 good response, 1 random bad header, 2 timeout, 3 flipped parity on byte 0, 4 wrong-id header
    task automatic apply_stimulus(input bit v0, input bit v1, input int kind, input bit directed);
        logic [7:0] pay [2][8];
        int         lens [2];
        int         w, d, rlen, n_wait;
        logic       wid;
        logic [7:0] hdr, b;
        bit         flip;
        n_wait = 0;
        while (busy && n_wait < 100) begin
            tick();
            n_wait++;
        end
        check_output("idleWait", {31'b0, busy}, 32'd0);
        for (int n = 0; n < 2; n++) begin
            lens[n] = $urandom_range(0, 7);
            for (int k = 0; k < 8; k++) pay[n][k] = 8'($urandom);
        end
        if (directed) begin
            lens[0] = 2;
            pay[0][0] = 8'hA1;
            pay[0][1] = 8'hB2;
            pay[0][2] = 8'hC3;
        end
        w = (v0 && v1) ? 1 - model_last : (v1 ? 1 : 0);
        model_last = w;
        wid = w[0];
        ob_q.push_back('{wid, {1'b1, wid, 3'b000, 3'(lens[w])}});
        for (int k = 0; k <= lens[w]; k++) ob_q.push_back('{wid, pay[w][k]});
        ob_q.push_back('{wid, 8'h00});

        rq0_valid = v0; rq0_len = 3'(lens[0]); rq0_data = pay[0][0];
        rq1_valid = v1; rq1_len = 3'(lens[1]); rq1_data = pay[1][0];
        tick();
        check_output("grantReady", {30'b0, rq1_ready, rq0_ready}, wid ? 32'd2 : 32'd1);
        rq0_valid = 1'b0; rq1_valid = 1'b0;
        rq0_len = 3'($urandom); rq1_len = 3'($urandom);
        for (int k = 0; k <= lens[w]; k++) begin
            if (wid) rq1_data = pay[1][k];
            else     rq0_data = pay[0][k];
            ib_data = 8'($urandom);
            ib_pty  = 1'($urandom);
            tick();
        end
        check_output("readyDrop", {30'b0, rq1_ready, rq0_ready}, 32'd0);

        d = directed ? 0 : $urandom_range(0, 4);
        if (kind != 2) begin
            for (int k = 0; k < d; k++) begin
                ib_data = {1'b0, 7'($urandom)};
                ib_pty  = 1'($urandom);
                tick();
            end
        end
        if (kind == 0 || kind == 3) begin
            rlen = directed ? 1 : (kind == 3 ? 2 : $urandom_range(0, 7));
            hdr = directed ? 8'h81 : {1'b1, wid, 3'($urandom), 3'(rlen)};
            ib_data = hdr;
            ib_pty  = ~^hdr;
            tick();
            for (int k = 0; k <= rlen; k++) begin
                b = directed ? (k == 0 ? 8'h11 : 8'h22) : 8'($urandom);
                flip = directed ? 1'b0 : (kind == 3 ? (k == 0) : ($urandom_range(0, 3) == 0));
                ib_data = b;
                ib_pty  = (~^b) ^ flip;
                rsp_q.push_back('{wid, b, (k == rlen), flip});
                tick();
            end
        end else if (kind == 1 || kind == 4) begin
            if (kind == 4) begin
                hdr = {1'b1, ~wid, 6'b0};
                ib_pty = ~^hdr;
            end else if ($urandom_range(0, 1) == 1) begin
                hdr = {1'b1, ~wid, 6'($urandom)};
                ib_pty = ~^hdr;
            end else begin
                hdr = {1'b1, wid, 6'($urandom)};
                ib_pty = ^hdr;
            end
            ib_data = hdr;
            rsp_q.push_back('{wid, hdr, 1'b1, 1'b1});
            tick();
        end else begin
            rsp_q.push_back('{wid, 8'h00, 1'b1, 1'b1});
            n_wait = 0;
            do begin
                ib_data = {1'b0, 7'($urandom)};
                ib_pty  = 1'($urandom);
                tick();
                n_wait++;
            end while (!rsp_valid && n_wait < 3 * TIMEOUT);
            check_output("timeoutCycles", n_wait, TIMEOUT);
        end
        ib_data = 8'h00;
        ib_pty  = 1'b1;
        tick();
        check_output("busyDrop", {31'b0, busy}, 32'd0);
        check_output("obIdle", {23'b0, ob_pty, ob_data}, 32'h100);
    endtask

    task automatic reset_mid_data();
        int w;
        while (busy) tick();
        w = 1 - model_last;
        ob_q.push_back('{w[0], {1'b1, w[0], 6'b000111}});
        rq0_valid = 1'b1; rq1_valid = 1'b1;
        rq0_len = 3'd7; rq1_len = 3'd7;
        rq0_data = 8'h5A; rq1_data = 8'h5A;
        ob_q.push_back('{w[0], 8'h5A});
        ob_q.push_back('{w[0], 8'h6B});
        ob_q.push_back('{w[0], 8'h7C});
        tick();
        rq0_valid = 1'b0; rq1_valid = 1'b0;
        tick();
        rq0_data = 8'h6B; rq1_data = 8'h6B;
        tick();
        ext_rst_n = 1'b0;
        #1;
        check_output("rstObData", {24'b0, ob_data}, 32'h00);
        check_output("rstObPty", {31'b0, ob_pty}, 32'd1);
        check_output("rstReady", {30'b0, rq1_ready, rq0_ready}, 32'd0);
        check_output("rstBusy", {31'b0, busy}, 32'd0);
        check_output("rstRspValid", {31'b0, rsp_valid}, 32'd0);
        ob_q.delete();
        tick();
        tick();
        ext_rst_n = 1'b1;
        model_last = 1;
    endtask

    initial begin
        #2 ext_rst_n = 1'b0;
        #1;
        check_output("resetOb", {23'b0, ob_pty, ob_data}, 32'h100);
        check_output("resetReady", {30'b0, rq1_ready, rq0_ready}, 32'd0);
        check_output("resetRsp", {20'b0, rsp_valid, rsp_err, rsp_last, rsp_id, rsp_data}, 32'd0);
        check_output("resetBusy", {31'b0, busy}, 32'd0);
        tick();
        tick();
        ext_rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b1, 0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 0, 1'b1);
        apply_stimulus(1'b1, 1'b0, 3, 1'b0);
        apply_stimulus(1'b1, 1'b0, 4, 1'b0);
        apply_stimulus(1'b0, 1'b1, 2, 1'b0);
        for (int i = 0; i < 24; i++) begin
            int pat;
            pat = $urandom_range(1, 3);
            apply_stimulus(pat[0], pat[1], $urandom_range(0, 4), 1'b0);
        end
        reset_mid_data();
        apply_stimulus(1'b1, 1'b1, 0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1, 1'b0);

        repeat (4) tick();
        check_output("obQueueDrain", ob_q.size(), 32'd0);
        check_output("rspQueueDrain", rsp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
